// File: rtl/rr_arb2_select_pkg.sv
// rr_arb2_select_pkg: shared state encodings and default parameters for the 2-way round-robin arbiter.
package rr_arb2_select_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_MAX_HOLD = 4;
    localparam int DEF_HOLD_W   = 3;
    localparam int DEF_STAT_W   = 8;

endpackage

// File: rtl/rr_arb2_select_stat_ctr.sv
// rr_arb2_stat_ctr: saturating event counter with increment and synchronous clear.
module rr_arb2_stat_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rr_arb2_select.sv
// rr_arb2_select: 2-requester round-robin arbiter with bounded grant hold, driving a 1-to-2 decoder.
// Define ARB_STATS_EN to build the per-requester saturating grant-event counters.
module rr_arb2_select
    import rr_arb2_select_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int STAT_W   = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    output logic              sel,
    output logic              sel_en,
    output logic              busy,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1
);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              own, oth;

    assign own = req[sel_q];
    assign oth = req[~sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (state_q == ARB_IDLE) begin
            if (|req) begin
                state_d = ARB_GRANT;
                sel_d   = (req == 2'b11) ? ~last_q : req[1];
                last_d  = sel_d;
                hold_d  = '0;
            end
        end else if (!own && !oth) begin
            state_d = ARB_IDLE;
            hold_d  = '0;
        end else if (!own || (MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD - 1))) begin
            // owner released, or its hold budget ran out while the other waits
            sel_d  = ~sel_q;
            last_d = ~sel_q;
            hold_d = '0;
        end else begin
            hold_d = (oth && MAX_HOLD != 0) ? hold_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = (state_q == ARB_GRANT);
    assign busy   = sel_en;

`ifdef ARB_STATS_EN
    logic grant_ev;
    assign grant_ev = (state_d == ARB_GRANT) && (state_q == ARB_IDLE || sel_d != sel_q);

    rr_arb2_stat_ctr #(.W(STAT_W)) u_cnt0 (
        .clk (clk),
        .rst (rst),
        .inc (grant_ev && !sel_d),
        .clr (1'b0),
        .cnt (grant_cnt0)
    );

    rr_arb2_stat_ctr #(.W(STAT_W)) u_cnt1 (
        .clk (clk),
        .rst (rst),
        .inc (grant_ev && sel_d),
        .clr (1'b0),
        .cnt (grant_cnt1)
    );
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_rr_arb2_select.sv
// tb_rr_arb2_select: directed vectors with scoreboard queue for rr_arb2_select plus an inline 1-to-2 decoder.
module tb_rr_arb2_select;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic       sel, sel_en, busy;
    logic [7:0] gc0, gc1;
    logic       o0, o1;

    always #5 clk = ~clk;

    rr_arb2_select #(.MAX_HOLD(4), .HOLD_W(3), .STAT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .sel        (sel),
        .sel_en     (sel_en),
        .busy       (busy),
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
    );

    assign o0 = sel_en & ~sel;
    assign o1 = sel_en & sel;

`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic       s;
        logic       e;
        logic [7:0] c0;
        logic [7:0] c1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m0 = 0;
    int   m1 = 0;

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] cexp(input int m);
        return STATS ? 8'(m) : 8'd0;
    endfunction

    task automatic step(input logic [1:0] r, input logic s, input logic e, input logic g);
        exp_t x;
        req = r;
        @(posedge clk);
        if (g) begin
            if (s) m1 = (m1 < 255) ? m1 + 1 : 255;
            else   m0 = (m0 < 255) ? m0 + 1 : 255;
        end
        x.s = s; x.e = e; x.c0 = cexp(m0); x.c1 = cexp(m1);
        q.push_back(x);
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            chk("sel", 8'(sel), 8'(x.s));
            chk("sel_en", 8'(sel_en), 8'(x.e));
            chk("busy", 8'(busy), 8'(x.e));
            chk("o0", 8'(o0), 8'(x.e & ~x.s));
            chk("o1", 8'(o1), 8'(x.e & x.s));
            chk("grant_cnt0", gc0, x.c0);
            chk("grant_cnt1", gc1, x.c1);
        end
    end

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_sel", 8'(sel), 8'd0);
        chk("rst_sel_en", 8'(sel_en), 8'd0);
        chk("rst_cnt0", gc0, 8'd0);
        chk("rst_cnt1", gc1, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(2'b00, 1'b0, 1'b0, 1'b0);
        // contest from reset: 0 wins, then alternation every 4 granted cycles
        step(2'b11, 1'b0, 1'b1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            repeat (3) step(2'b11, r[0], 1'b1, 1'b0);
            step(2'b11, ~r[0], 1'b1, 1'b1);
        end
        // owner 1 drops with 0 waiting: no bubble, hold restarts
        step(2'b01, 1'b0, 1'b1, 1'b1);
        step(2'b01, 1'b0, 1'b1, 1'b0);
        repeat (3) step(2'b11, 1'b0, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b1, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b1, 1'b1);
        // async reset in the middle of a grant
        #2 rst = 1'b1;
        #1;
        chk("midrst_sel_en", 8'(sel_en), 8'd0);
        chk("midrst_o0", 8'(o0), 8'd0);
        chk("midrst_cnt0", gc0, 8'd0);
        m0 = 0;
        m1 = 0;
        @(negedge clk);
        rst = 1'b0;
        step(2'b11, 1'b0, 1'b1, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(2'b01, 1'b0, 1'b1, 1'b1);
            step(2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_cnt0", gc0, STATS ? 8'd255 : 8'd0);
        repeat (2) @(negedge clk);
        chk("queue_drained", 8'(q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
